// File: rtl/disp_mux4.sv
// ---------------------------------------------------------------------------
// disp_mux4 -- four-digit time-multiplexed seven-segment display driver.
//
// Takes a snapshot of a 16-bit value (four hex nibbles) once per scan frame,
// so a frame never mixes old and new digits. The digits are scanned at a
// prescaled rate. Segment, decimal-point and digit-enable lines are active-low.
//
// Parameters
//   DIV   clk cycles per digit slot (1 .. 2**DIVW-1)
//   DIVW  prescaler counter width
//
// Ports
//   clk_i    system clock; all state changes on posedge
//   rst_i    synchronous reset, active-high
//   en_i     display enable; 0 blanks all outputs while scanning continues
//   val_i    value to show; val_i[3:0] -> digit0 (rightmost) .. [15:12] -> digit3
//   dp_in_i  decimal points; dp_in_i[i]=1 lights the DP of digit i (sampled live)
//   segn_o   segments, active-low, segn_o[0]=a .. segn_o[6]=g
//   dpn_o    decimal point, active-low
//   dign_o   digit enables, active-low; dign_o[i] selects digit i
//   frame_o  1-cycle pulse on the edge where a new val_i snapshot is taken
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, blanks the segments of leading-zero
//                          digits 3..1. Digit0 always shows its nibble.
//                          dign_o and dpn_o are not affected.
// ---------------------------------------------------------------------------
module disp_mux4 #(
   parameter int unsigned DIV  = 50000,
   parameter int unsigned DIVW = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [15:0] val_i,
   input  logic [3:0]  dp_in_i,
   output logic [6:0]  segn_o,
   output logic        dpn_o,
   output logic [3:0]  dign_o,
   output logic        frame_o
);

   localparam logic [DIVW-1:0] DIV_M1 = DIVW'(DIV - 1);
   localparam logic [DIVW-1:0] ONE    = DIVW'(1);

   // Hex to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] dec7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [DIVW-1:0] pcnt_q, pcnt_d;
   logic [1:0]      idx_q,  idx_d;
   logic [15:0]     snap_q, snap_d;
   logic            frame_q, frame_d;
   logic [3:0]      dign_q, dign_d;
   logic [6:0]      segn_q, segn_d;
   logic            dpn_q,  dpn_d;

   logic            tick;
   logic            snap_now;
   logic [3:0]      nib;
   logic            lz_blank;

   assign tick     = (pcnt_q == DIV_M1);
   // End of the digit-3 slot closes the frame and opens the next one
   assign snap_now = tick && (idx_q == 2'd3);

   // Nibble of the digit currently being scanned
   always_comb begin
      nib = snap_q[3:0];
      case (idx_q)
         2'd0: nib = snap_q[3:0];
         2'd1: nib = snap_q[7:4];
         2'd2: nib = snap_q[11:8];
         2'd3: nib = snap_q[15:12];
         default: nib = snap_q[3:0];
      endcase
   end

   // A digit is a leading zero when it and every digit left of it are zero
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      lz_blank = 1'b0;
      case (idx_q)
         2'd3: lz_blank = (snap_q[15:12] == 4'h0);
         2'd2: lz_blank = (snap_q[15:8]  == 8'h00);
         2'd1: lz_blank = (snap_q[15:4]  == 12'h000);
         default: lz_blank = 1'b0;
      endcase
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      pcnt_d  = tick ? '0 : pcnt_q + ONE;
      idx_d   = tick ? idx_q + 2'd1 : idx_q;
      snap_d  = snap_now ? val_i : snap_q;
      frame_d = snap_now;

      dign_d  = 4'b1111;
      segn_d  = 7'h7F;
      dpn_d   = 1'b1;
      // Outputs decode the pre-edge idx/snap, so they trail idx by one cycle
      if (en_i) begin
         dign_d = ~(4'b0001 << idx_q);
         segn_d = lz_blank ? 7'h7F : dec7(nib);
         dpn_d  = ~dp_in_i[idx_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pcnt_q  <= '0;
         idx_q   <= 2'd0;
         snap_q  <= 16'h0000;
         frame_q <= 1'b0;
         dign_q  <= 4'b1111;
         segn_q  <= 7'h7F;
         dpn_q   <= 1'b1;
      end else begin
         pcnt_q  <= pcnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         frame_q <= frame_d;
         dign_q  <= dign_d;
         segn_q  <= segn_d;
         dpn_q   <= dpn_d;
      end
   end

   assign segn_o  = segn_q;
   assign dpn_o   = dpn_q;
   assign dign_o  = dign_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_disp_mux4.sv
// ---------------------------------------------------------------------------
// tb_disp_mux4 -- scoreboard bench for disp_mux4 (DIV=4).
// The driver computes the expected registered outputs for each clock edge
// from a time-based model: edges since reset release give the digit slot
// and frame boundaries directly. The expected outputs are queued. A monitor
// pops one entry per edge and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_disp_mux4;

   localparam int DIV = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] val;
   logic [3:0]  dp;
   logic [6:0]  segn;
   logic        dpn;
   logic [3:0]  dign;
   logic        frame;

   disp_mux4 #(.DIV(DIV), .DIVW(16)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en),
      .val_i   (val),
      .dp_in_i (dp),
      .segn_o  (segn),
      .dpn_o   (dpn),
      .dign_o  (dign),
      .frame_o (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       frame;
      logic [3:0] dign;
      logic [6:0] segn;
      logic       dpn;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model state: edges since reset release and the last snapshot taken
   int          m_e    = 0;
   logic [15:0] m_snap = 16'h0000;

   // Drive inputs for the next posedge, queue what that edge must produce,
   // then advance to the following negedge.
   task automatic step(input logic r, input logic e_n, input logic [15:0] v,
                       input logic [3:0] d);
      exp_t x;
      int   dig;
      logic [15:0] upper;
      rst = r; en = e_n; val = v; dp = d;
      if (r) begin
         x = '{frame: 1'b0, dign: 4'b1111, segn: 7'h7F, dpn: 1'b1};
         m_e = 0;
         m_snap = 16'h0000;
      end else begin
         dig   = (m_e / DIV) % 4;
         upper = m_snap >> (4 * dig);
         x.frame = ((m_e % (4 * DIV)) == (4 * DIV - 1));
         if (e_n) begin
            x.dign = 4'hF ^ (4'(1) << dig);
            x.segn = DEC[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
            if (dig > 0 && upper == 16'h0000) x.segn = 7'h7F;
`endif
            x.dpn  = ~d[dig];
         end else begin
            x.dign = 4'b1111;
            x.segn = 7'h7F;
            x.dpn  = 1'b1;
         end
         if (x.frame) m_snap = v;
         m_e++;
      end
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic e_n, input logic [15:0] v,
                      input logic [3:0] d);
      for (int i = 0; i < n; i++) step(1'b0, e_n, v, d);
   endtask

   // Monitor: one registered output set per edge
   initial begin : monitor
      exp_t x;
      int   cyc;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_chk++;
            if (frame !== x.frame) begin
               n_fail++;
               $display("FAIL cyc %0d frame: got %b expected %b", cyc, frame, x.frame);
            end
            n_chk++;
            if (dign !== x.dign) begin
               n_fail++;
               $display("FAIL cyc %0d dign: got %b expected %b", cyc, dign, x.dign);
            end
            n_chk++;
            if (segn !== x.segn) begin
               n_fail++;
               $display("FAIL cyc %0d segn: got %b expected %b (dign exp %b)",
                        cyc, segn, x.segn, x.dign);
            end
            n_chk++;
            if (dpn !== x.dpn) begin
               n_fail++;
               $display("FAIL cyc %0d dpn: got %b expected %b", cyc, dpn, x.dpn);
            end
         end
         cyc++;
      end
   end

   initial begin : driver
      rst = 1'b1; en = 1'b1; val = 16'h1234; dp = 4'h0;
      // Reset, then the first frame shows the reset snapshot (all zeros)
      step(1'b1, 1'b1, 16'h1234, 4'h0);
      step(1'b1, 1'b1, 16'h1234, 4'h0);
      run(16, 1'b1, 16'h1234, 4'h0);
      // Two frames of 1234
      run(20, 1'b1, 16'h1234, 4'h0);
      // Change to ABCD mid-frame; the new value appears only after the next frame pulse
      run(4, 1'b1, 16'hABCD, 4'h0);
      run(28, 1'b1, 16'hABCD, 4'h0);
      // Blank mid-scan, frame pulses continue, then resume
      run(3, 1'b1, 16'hABCD, 4'h0);
      run(21, 1'b0, 16'h5678, 4'h0);
      run(16, 1'b1, 16'h5678, 4'h0);
      // Decimal point on digit 2 only
      run(32, 1'b1, 16'h5678, 4'b0100);
      // Leading-zero patterns
      run(32, 1'b1, 16'h0050, 4'h0);
      run(32, 1'b1, 16'h0000, 4'h0);
      run(32, 1'b1, 16'h0F00, 4'b1001);
      // Reset mid-scan
      run(5, 1'b1, 16'h9E3C, 4'h0);
      step(1'b1, 1'b1, 16'h9E3C, 4'h0);
      run(40, 1'b1, 16'h9E3C, 4'h0);
      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic [15:0] rv;
         rv = 16'($urandom);
         // Bias toward leading-zero values part of the time
         if ($urandom_range(0, 3) == 0) rv = rv >> (4 * $urandom_range(1, 4));
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), rv,
              4'($urandom));
      end
      @(posedge clk);
      #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
